jtpang_objdma: RTL and testbench

- Bus-master DMA engine: the responder to the main CPU's DMA trigger and to its bus-request handshake.
- On a CPU OUT to the DMA port (dma_go), it requests the Z80 bus and reads the object table from the CPU-side video memory.
- It copies the table byte by byte into the object line-buffer RAM, then releases the bus.
- It sits between the main CPU block and the object renderer, and is driven by the same CPU clock enable.

---
 rtl/jtpang_objdma.sv | 169 ++++++++++++++++
 tb/tb_jtpang_objdma.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpang_objdma.sv
// Object-table DMA: on a dma_go edge, takes the Z80 bus and copies 2**OW bytes
// from the CPU video window into the object line buffer, then returns the bus.
module jtpang_objdma #(
  parameter int            AW       = 12,
  parameter int            OW       = 9,
  parameter logic [AW-1:0] SRC_BASE = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          busak_n,
  output logic          busrq_n,
  output logic [AW-1:0] dma_addr,
  output logic          dma_rd,
  input  logic [7:0]    dma_din,
  output logic [OW-1:0] obj_addr,
  output logic [7:0]    obj_dout,
  output logic          obj_we,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  localparam logic [OW:0] CNT_LAST = {1'b0, {OW{1'b1}}};
  localparam logic [OW:0] CNT_ONE  = {{OW{1'b0}}, 1'b1};

  logic [2:0]    state_q, state_d;
  logic [OW:0]   cnt_q, cnt_d;
  logic          go_prev_q, go_prev_d;
  logic          go_pend_q, go_pend_d;
  logic          busrq_n_q, busrq_n_d;
  logic          dma_rd_q, dma_rd_d;
  logic [AW-1:0] dma_addr_q, dma_addr_d;
  logic          obj_we_q, obj_we_d;
  logic [OW-1:0] obj_addr_q, obj_addr_d;
  logic [7:0]    obj_dout_q, obj_dout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [OW:0]   cnt_inc;
  logic [AW-1:0] addr_cur, addr_nxt;

  assign cnt_inc  = cnt_q + CNT_ONE;
  assign addr_cur = SRC_BASE + AW'(cnt_q);
  assign addr_nxt = SRC_BASE + AW'(cnt_inc);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    go_prev_d  = dma_go;
    go_pend_d  = go_pend_q;
    busrq_n_d  = busrq_n_q;
    dma_rd_d   = dma_rd_q;
    dma_addr_d = dma_addr_q;
    obj_we_d   = obj_we_q;
    obj_addr_d = obj_addr_q;
    obj_dout_d = obj_dout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Edge capture runs every clk so a short go pulse between cen ticks is not lost.
    if (dma_go && !go_prev_q && state_q == S_IDLE) begin
      go_pend_d = 1'b1;
    end

    if (cen) begin
      case (state_q)
        S_IDLE: begin
          if (go_pend_q) begin
            go_pend_d = 1'b0;
            cnt_d     = '0;
            busy_d    = 1'b1;
            busrq_n_d = 1'b0;
            state_d   = S_REQ;
          end
        end
        S_REQ: begin
          if (!busak_n) begin
            dma_rd_d   = 1'b1;
            dma_addr_d = addr_cur;
            state_d    = S_RD;
          end
        end
        S_RD: begin
          // A lost grant parks the read; the byte is re-read once the grant returns.
          if (busak_n) begin
            dma_rd_d = 1'b0;
          end else if (!dma_rd_q) begin
            dma_rd_d = 1'b1;
          end else begin
            dma_rd_d   = 1'b0;
            obj_we_d   = 1'b1;
            obj_addr_d = cnt_q[OW-1:0];
            obj_dout_d = dma_din;
            state_d    = S_WR;
          end
        end
        S_WR: begin
          obj_we_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            busrq_n_d = 1'b1;
            state_d   = S_REL;
          end else begin
            cnt_d      = cnt_inc;
            dma_rd_d   = 1'b1;
            dma_addr_d = addr_nxt;
            state_d    = S_RD;
          end
        end
        S_REL: begin
          if (busak_n) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      go_prev_q  <= 1'b0;
      go_pend_q  <= 1'b0;
      busrq_n_q  <= 1'b1;
      dma_rd_q   <= 1'b0;
      dma_addr_q <= SRC_BASE;
      obj_we_q   <= 1'b0;
      obj_addr_q <= '0;
      obj_dout_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      go_prev_q  <= go_prev_d;
      go_pend_q  <= go_pend_d;
      busrq_n_q  <= busrq_n_d;
      dma_rd_q   <= dma_rd_d;
      dma_addr_q <= dma_addr_d;
      obj_we_q   <= obj_we_d;
      obj_addr_q <= obj_addr_d;
      obj_dout_q <= obj_dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busrq_n  = busrq_n_q;
  assign dma_rd   = dma_rd_q;
  assign dma_addr = dma_addr_q;
  assign obj_we   = obj_we_q;
  assign obj_addr = obj_addr_q;
  assign obj_dout = obj_dout_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: two instances (base 0 and base FF8, 16-byte table),
// scoreboard queues filled from a source-memory model, negedge monitor pops them.
module tb_jtpang_objdma;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  int          cen_div = 1;

  logic        go0 = 1'b0, go1 = 1'b0;
  logic        ovr0 = 1'b0;
  logic [3:0]  sh0 = 4'hF, sh1 = 4'hF;
  logic        busak0, busak1;
  logic        busrq0, busrq1, rd0, rd1, we0, we1, busy0, busy1, done0, done1;
  logic [11:0] addr0, addr1;
  logic [7:0]  din0, din1, odout0, odout1;
  logic [3:0]  oaddr0, oaddr1;

  logic [7:0]  src0 [0:4095];
  logic [7:0]  src1 [0:4095];

  wr_t         exp_w0[$], exp_w1[$];
  logic [11:0] exp_r0[$], exp_r1[$];

  int checks = 0, failures = 0;
  int cyc = 0, rq_low0 = 0, rq_fall0 = 0, done_hi0 = 0, done_hi1 = 0;
  int pause_we = 0, last_we0 = 0;
  logic spacing_en = 1'b0;

  assign busak0 = ovr0 | sh0[3];
  assign busak1 = sh1[3];
  assign din0   = src0[addr0];
  assign din1   = src1[addr1];

  jtpang_objdma #(.AW(12), .OW(4), .SRC_BASE(12'h000)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(go0), .busak_n(busak0),
    .busrq_n(busrq0), .dma_addr(addr0), .dma_rd(rd0), .dma_din(din0),
    .obj_addr(oaddr0), .obj_dout(odout0), .obj_we(we0), .busy(busy0), .done(done0)
  );

  jtpang_objdma #(.AW(12), .OW(4), .SRC_BASE(12'hFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(go1), .busak_n(busak1),
    .busrq_n(busrq1), .dma_addr(addr1), .dma_rd(rd1), .dma_din(din1),
    .obj_addr(oaddr1), .obj_dout(odout1), .obj_we(we1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  // Clock-enable divider and a Z80 that grants/releases 3 clk after the request moves.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph  = (ph + 1) % cen_div;
      cen = (ph == 0);
      sh0 = {sh0[2:0], busrq0};
      sh1 = {sh1[2:0], busrq1};
    end
  end

  // Reference: object byte i comes from source address (base + i) mod 4096.
  function automatic void push_xfer(input int which);
    int base;
    base = which ? 12'hFF8 : 0;
    for (int i = 0; i < 16; i++) begin
      if (which == 0) begin
        exp_w0.push_back({4'(i), src0[(base + i) % 4096]});
        exp_r0.push_back(12'((base + i) % 4096));
      end else begin
        exp_w1.push_back({4'(i), src1[(base + i) % 4096]});
        exp_r1.push_back(12'((base + i) % 4096));
      end
    end
  endfunction

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Monitor: one line per scoreboard transaction.
  initial begin
    wr_t         w;
    logic [11:0] ra;
    logic        rq_prev;
    rq_prev = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (!busrq0) rq_low0++;
        if (!busrq0 && rq_prev) rq_fall0++;
        if (done0) done_hi0++;
        if (done1) done_hi1++;
        if (ovr0 && we0) pause_we++;
        if (cen && we0) begin
          checks++;
          if (exp_w0.size() == 0) begin
            failures++;
            $display("FAIL dut0_write unexpected addr=%0d data=%02h required=none", oaddr0, odout0);
          end else begin
            w = exp_w0.pop_front();
            if (oaddr0 !== w.a || odout0 !== w.d) begin
              failures++;
              $display("FAIL dut0_write actual=%0d/%02h required=%0d/%02h", oaddr0, odout0, w.a, w.d);
            end else begin
              $display("dut0 write addr=%0d data=%02h ok", oaddr0, odout0);
            end
          end
          if (spacing_en && oaddr0 != 4'd0) begin
            checks++;
            if (cyc - last_we0 != 8) begin
              failures++;
              $display("FAIL sparse_byte_clks actual=%0d required=8", cyc - last_we0);
            end
          end
          last_we0 = cyc;
        end
        if (cen && rd0 && !busak0) begin
          checks++;
          ra = (exp_r0.size() == 0) ? 12'hxxx : exp_r0.pop_front();
          if (addr0 !== ra) begin
            failures++;
            $display("FAIL dut0_read_addr actual=%03h required=%03h", addr0, ra);
          end
        end
        if (cen && we1) begin
          checks++;
          if (exp_w1.size() == 0) begin
            failures++;
            $display("FAIL dut1_write unexpected addr=%0d data=%02h required=none", oaddr1, odout1);
          end else begin
            w = exp_w1.pop_front();
            if (oaddr1 !== w.a || odout1 !== w.d) begin
              failures++;
              $display("FAIL dut1_write actual=%0d/%02h required=%0d/%02h", oaddr1, odout1, w.a, w.d);
            end else begin
              $display("dut1 write addr=%0d data=%02h ok", oaddr1, odout1);
            end
          end
        end
        if (cen && rd1 && !busak1) begin
          checks++;
          ra = (exp_r1.size() == 0) ? 12'hxxx : exp_r1.pop_front();
          if (addr1 !== ra) begin
            failures++;
            $display("FAIL dut1_read_addr actual=%03h required=%03h", addr1, ra);
          end
        end
      end
      rq_prev = busrq0;
    end
  end

  task automatic pulse_go(input int which);
    @(posedge clk);
    #2;
    if (which == 0) go0 = 1'b1; else go1 = 1'b1;
    @(posedge clk);
    #2;
    if (which == 0) go0 = 1'b0; else go1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget, input string name);
    int s;
    s = which ? done_hi1 : done_hi0;
    for (int i = 0; i < budget && (which ? done_hi1 : done_hi0) == s; i++) @(negedge clk);
    chk({name, "_done_seen"}, int'((which ? done_hi1 : done_hi0) != s), 1);
    repeat (5) @(negedge clk);
    chk({name, "_done_clks"}, (which ? done_hi1 : done_hi0) - s, 1);
    chk({name, "_writes_left"}, which ? exp_w1.size() : exp_w0.size(), 0);
    chk({name, "_reads_left"}, which ? exp_r1.size() : exp_r0.size(), 0);
    chk({name, "_busy_after"}, int'(which ? busy1 : busy0), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, fall, pw, sd;
    for (int i = 0; i < 4096; i++) begin
      src0[i] = 8'($urandom);
      src1[i] = 8'($urandom);
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busrq_n", int'(busrq0), 1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_outputs", int'({rd0, we0, busy0, done0}), 0);
    chk("rst_addrs", int'({addr0, oaddr0, odout0}), 0);
    chk("rst_wrap_dma_addr", int'(addr1), 12'hFF8);

    // Basic copy.
    for (int i = 0; i < 16; i++) src0[i] = 8'hA0 + 8'(i);
    push_xfer(0);
    lo = rq_low0;
    fall = rq_fall0;
    pulse_go(0);
    wait_done(0, 300, "basic");
    chk("basic_busrq_low_clks", rq_low0 - lo, 36);
    chk("basic_busrq_asserts", rq_fall0 - fall, 1);

    // Held go with a stray pulse mid-transfer.
    cen_div = 2;
    for (int i = 0; i < 16; i++) src0[i] = 8'($urandom);
    push_xfer(0);
    fall = rq_fall0;
    @(posedge clk);
    #2 go0 = 1'b1;
    repeat (40) @(posedge clk);
    #2 go0 = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("held_busy_mid", int'(busy0), 1);
    go0 = 1'b1;
    @(posedge clk);
    #2 go0 = 1'b0;
    wait_done(0, 400, "held");
    repeat (60) @(negedge clk);
    chk("held_busrq_asserts", rq_fall0 - fall, 1);

    // Sparse cen.
    cen_div = 4;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 16; i++) src0[i] = 8'hA0 + 8'(i);
    push_xfer(0);
    spacing_en = 1'b1;
    pulse_go(0);
    wait_done(0, 800, "sparse");
    spacing_en = 1'b0;

    // Pause on byte 5.
    cen_div = 1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 16; i++) src0[i] = 8'($urandom);
    push_xfer(0);
    pw = pause_we;
    pulse_go(0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (rd0 && addr0 == 12'd5) break;
    end
    chk("pause_found_rd5", int'(rd0 && addr0 == 12'd5), 1);
    #1 ovr0 = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("pause_rd_dropped", int'(rd0), 0);
    chk("pause_addr_held", int'(addr0), 5);
    ovr0 = 1'b0;
    wait_done(0, 300, "pause");
    chk("pause_we_during", pause_we - pw, 0);

    // Source address wrap.
    push_xfer(1);
    pulse_go(1);
    wait_done(1, 300, "wrap");

    // Reset during byte 7's write.
    for (int i = 0; i < 16; i++) src0[i] = 8'($urandom);
    push_xfer(0);
    pulse_go(0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (we0 && oaddr0 == 4'd7) break;
    end
    chk("rstmid_found_wr7", int'(we0 && oaddr0 == 4'd7), 1);
    sd = done_hi0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busrq_n", int'(busrq0), 1);
    chk("rstmid_obj_we", int'(we0), 0);
    chk("rstmid_busy", int'(busy0), 0);
    chk("rstmid_writes_left", exp_w0.size(), 9);
    chk("rstmid_reads_left", exp_r0.size(), 8);
    exp_w0.delete();
    exp_r0.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rstmid_no_done", done_hi0 - sd, 0);
    for (int i = 0; i < 16; i++) src0[i] = 8'($urandom);
    push_xfer(0);
    pulse_go(0);
    wait_done(0, 300, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
